psram_qpi_responder: RTL and testbench

// Synthesizable responder for the LY68L6400 quad-SPI protocol: the device side of our PSRAM controller link.

---
 rtl/psram_qpi_pkg.sv | 26 ++
 rtl/psram_model_ram.sv | 23 ++
 rtl/psram_qpi_responder.sv | 205 ++++++++++++++++++++
 tb/tb_psram_qpi_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_qpi_pkg.sv
// Shared constants and state encoding for the PSRAM QPI responder.
package psram_qpi_pkg;

  localparam int unsigned NibW     = 4;
  localparam int unsigned AddrW    = 24;
  localparam int unsigned AddrNibs = AddrW / NibW;

  localparam logic [7:0] CmdRstEn   = 8'h66;
  localparam logic [7:0] CmdRst     = 8'h99;
  localparam logic [7:0] CmdSpi2Qpi = 8'h35;
  localparam logic [7:0] CmdQpiExit = 8'hF5;
  localparam logic [7:0] CmdQRead   = 8'hEB;
  localparam logic [7:0] CmdQWrite  = 8'h38;

  typedef enum logic [2:0] {
    StIdle,
    StSpiCmd,
    StQCmd,
    StQAddr,
    StQWait,
    StQRdata,
    StQWdata,
    StIgnore
  } state_e;

endpackage

// File: rtl/psram_model_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port. Never cleared.
module psram_model_ram #(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [7:0]           wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [7:0]           rdata_o
);

  logic [7:0] mem [2**ADDR_BITS];

  // Write port plus registered read; read-before-write on a same-address collision.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/psram_qpi_responder.sv
// Device side of the LY68L6400 quad-SPI link: SPI init commands, QPI fast read (EBh)
// and quad write (38h) backed by a small byte RAM. Requires ADDR_BITS >= 5, WAIT_CYC >= 1.
module psram_qpi_responder
  import psram_qpi_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned WAIT_CYC  = 6
) (
  input  logic       mem_clk,
  input  logic       rst_n,
  input  logic       mem_ce,
  inout  wire  [3:0] mem_sio,
  output logic       qpi_mode,
  output logic       busy,
  output logic [7:0] last_cmd,
  output logic       cmd_err
);

  localparam logic [4:0] AddrLast = 5'(AddrNibs - 1);
  localparam logic [4:0] WaitLast = 5'(WAIT_CYC - 1);
  localparam logic [ADDR_BITS-1:0] PtrOne = ADDR_BITS'(1);

  state_e               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [6:0]           cmd_sr_q, cmd_sr_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic                 is_wr_q, is_wr_d;
  logic                 lo_q, lo_d;       // next nibble is the low half of the byte
  logic [3:0]           wr_hi_q, wr_hi_d;
  logic                 qpi_q, qpi_d;
  logic                 armed_q, armed_d;
  logic [7:0]           last_q, last_d;
  logic                 err_q, err_d;
  logic                 busy_q;
  logic                 hold_off_q, hold_off_d; // CE window cut by reset: ignore the rest of it

  logic [3:0] sio_in;
  logic [7:0] cmd_byte;
  logic       ram_we;
  logic [7:0] ram_rdata;
  logic [3:0] nib_q;
  logic       drv_q;

  assign sio_in = mem_sio;

  // Next-state decode of the link protocol; a high CE at any edge aborts to idle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_sr_d   = cmd_sr_q;
    ptr_d      = ptr_q;
    is_wr_d    = is_wr_q;
    lo_d       = lo_q;
    wr_hi_d    = wr_hi_q;
    qpi_d      = qpi_q;
    armed_d    = armed_q;
    last_d     = last_q;
    hold_off_d = hold_off_q;
    err_d      = 1'b0;
    ram_we     = 1'b0;
    cmd_byte   = 8'h00;

    if (mem_ce) begin
      state_d    = StIdle;
      hold_off_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hold_off_q) begin
            state_d = StIgnore;
          end else if (qpi_q) begin
            cmd_sr_d = {3'b000, sio_in};
            state_d  = StQCmd;
          end else begin
            cmd_sr_d = {6'b000000, sio_in[0]};
            cnt_d    = 5'd1;
            state_d  = StSpiCmd;
          end
        end
        StSpiCmd: begin
          cmd_byte = {cmd_sr_q, sio_in[0]};
          cmd_sr_d = cmd_byte[6:0];
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            last_d  = cmd_byte;
            armed_d = (cmd_byte == CmdRstEn);
            if (cmd_byte == CmdRst && armed_q) qpi_d = 1'b0;
            if (cmd_byte == CmdSpi2Qpi) qpi_d = 1'b1;
            state_d = StIgnore;
          end
        end
        StQCmd: begin
          cmd_byte = {cmd_sr_q[3:0], sio_in};
          last_d   = cmd_byte;
          armed_d  = (cmd_byte == CmdRstEn);
          cnt_d    = 5'd0;
          state_d  = StIgnore;
          case (cmd_byte)
            CmdQRead, CmdQWrite: begin
              is_wr_d = (cmd_byte == CmdQWrite);
              state_d = StQAddr;
            end
            CmdQpiExit: qpi_d = 1'b0;
            CmdRstEn:   ;
            CmdRst:     if (armed_q) qpi_d = 1'b0;
            default:    err_d = 1'b1;
          endcase
        end
        StQAddr: begin
          // Only the low ADDR_BITS of the 24-bit address survive the shift.
          ptr_d = {ptr_q[ADDR_BITS-5:0], sio_in};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == AddrLast) begin
            cnt_d   = 5'd0;
            lo_d    = 1'b0;
            state_d = is_wr_q ? StQWdata : StQWait;
          end
        end
        StQWait: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == WaitLast) begin
            lo_d    = 1'b0;
            state_d = StQRdata;
          end
        end
        StQRdata: begin
          // Advance the read address as the low nibble goes out, so the registered
          // RAM output holds the next byte by the time its high nibble is due.
          lo_d = ~lo_q;
          if (!lo_q) ptr_d = ptr_q + PtrOne;
        end
        StQWdata: begin
          if (!lo_q) begin
            wr_hi_d = sio_in;
            lo_d    = 1'b1;
          end else begin
            ram_we = 1'b1;
            lo_d   = 1'b0;
            ptr_d  = ptr_q + PtrOne;
          end
        end
        StIgnore: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // Rising-edge state register with synchronous reset.
  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cmd_sr_q   <= '0;
      ptr_q      <= '0;
      is_wr_q    <= 1'b0;
      lo_q       <= 1'b0;
      wr_hi_q    <= '0;
      qpi_q      <= 1'b0;
      armed_q    <= 1'b0;
      last_q     <= 8'h00;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      hold_off_q <= !mem_ce;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_sr_q   <= cmd_sr_d;
      ptr_q      <= ptr_d;
      is_wr_q    <= is_wr_d;
      lo_q       <= lo_d;
      wr_hi_q    <= wr_hi_d;
      qpi_q      <= qpi_d;
      armed_q    <= armed_d;
      last_q     <= last_d;
      err_q      <= err_d;
      busy_q     <= !mem_ce && (state_d != StIdle);
      hold_off_q <= hold_off_d;
    end
  end

  psram_model_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk_i  (mem_clk),
    .we_i   (ram_we && rst_n),
    .waddr_i(ptr_q),
    .wdata_i({wr_hi_q, sio_in}),
    .raddr_i(ptr_q),
    .rdata_o(ram_rdata)
  );

  // Falling-edge output register: nibble plus a drive-valid bit, so the bus is only
  // enabled from the falling edge after entering the data phase.
  always_ff @(negedge mem_clk) begin
    drv_q <= (state_q == StQRdata);
    nib_q <= lo_q ? ram_rdata[3:0] : ram_rdata[7:4];
  end

  assign mem_sio  = (!mem_ce && state_q == StQRdata && drv_q) ? nib_q : 4'bzzzz;
  assign qpi_mode = qpi_q;
  assign busy     = busy_q;
  assign last_cmd = last_q;
  assign cmd_err  = err_q;

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Bench for psram_qpi_responder: controller-side driver, byte-level memory model and a
// per-cycle output comparator. Bus pulled up, so a released bus reads 4'hF.
module tb_psram_qpi_responder;

  localparam int unsigned AddrBits = 10;
  localparam int unsigned WaitCyc  = 6;
  localparam int unsigned Depth    = 1 << AddrBits;
  localparam logic [3:0]  Released = 4'hF;

  logic       mem_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       mem_ce  = 1'b1;
  logic [3:0] sio_drv = 4'h0;
  logic       sio_oe  = 1'b0;
  wire  [3:0] mem_sio;
  logic       qpi_mode, busy, cmd_err;
  logic [7:0] last_cmd;

  assign mem_sio = sio_oe ? sio_drv : 4'bzzzz;
  pullup (mem_sio[0]);
  pullup (mem_sio[1]);
  pullup (mem_sio[2]);
  pullup (mem_sio[3]);

  psram_qpi_responder #(
    .ADDR_BITS(AddrBits),
    .WAIT_CYC (WaitCyc)
  ) dut (
    .mem_clk (mem_clk),
    .rst_n   (rst_n),
    .mem_ce  (mem_ce),
    .mem_sio (mem_sio),
    .qpi_mode(qpi_mode),
    .busy    (busy),
    .last_cmd(last_cmd),
    .cmd_err (cmd_err)
  );

  always #5 mem_clk = ~mem_clk;

  // Model state and per-edge expectations.
  logic [7:0] m_mem [Depth];
  logic       m_qpi   = 1'b0;
  logic       m_armed = 1'b0;
  logic [7:0] m_last  = 8'h00;
  logic       e_busy  = 1'b0;
  logic       e_err   = 1'b0;
  logic [3:0] e_sio   = Released;
  logic [7:0] wbuf [$];
  logic [7:0] rbuf [$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
  endtask

  // Compare every output just after each rising edge.
  always @(posedge mem_clk) begin
    #1;
    check("qpi_mode", 32'(qpi_mode), 32'(m_qpi));
    check("busy", 32'(busy), 32'(e_busy));
    check("last_cmd", 32'(last_cmd), 32'(m_last));
    check("cmd_err", 32'(cmd_err), 32'(e_err));
    check("sio", 32'(mem_sio), 32'(e_sio));
  end

  // One controller cycle: drive on the falling edge, set default expectations.
  task automatic cyc(input logic ce, input logic oe, input logic [3:0] d);
    @(negedge mem_clk);
    mem_ce  = ce;
    sio_oe  = oe;
    sio_drv = d;
    e_err   = 1'b0;
    e_busy  = !ce && rst_n;
    e_sio   = oe ? d : Released;
  endtask

  task automatic end_window();
    cyc(1'b1, 1'b0, 4'h0);
  endtask

  task automatic spi_cmd(input logic [7:0] b);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, {3'b000, b[7-k]});
      if (k == 7) begin
        m_last = b;
        if (b == 8'h99 && m_armed) m_qpi = 1'b0;
        if (b == 8'h35) m_qpi = 1'b1;
        m_armed = (b == 8'h66);
      end
    end
    end_window();
  endtask

  task automatic q_cmd(input logic [7:0] b);
    cyc(1'b0, 1'b1, b[7:4]);
    cyc(1'b0, 1'b1, b[3:0]);
    m_last = b;
    case (b)
      8'hEB, 8'h38, 8'h66: ;
      8'hF5: m_qpi = 1'b0;
      8'h99: if (m_armed) m_qpi = 1'b0;
      default: e_err = 1'b1;
    endcase
    m_armed = (b == 8'h66);
  endtask

  task automatic q_addr(input logic [23:0] a, input int n_nib);
    for (int i = 0; i < n_nib; i++) cyc(1'b0, 1'b1, a[23-4*i -: 4]);
  endtask

  // Quad write of n_nib nibbles taken from wbuf; an odd trailing nibble is dropped.
  task automatic q_write(input logic [23:0] a, input int n_nib);
    int idx;
    logic [7:0] b;
    q_cmd(8'h38);
    q_addr(a, 6);
    for (int i = 0; i < n_nib; i++) begin
      b = wbuf[i/2];
      cyc(1'b0, 1'b1, (i % 2 == 0) ? b[7:4] : b[3:0]);
      if (i % 2 == 1) begin
        idx = (int'(a[AddrBits-1:0]) + i / 2) % Depth;
        m_mem[idx] = b;
      end
    end
    end_window();
  endtask

  // Quad read; nibble n is expected on the bus after edge 8+WaitCyc+n. rst_k >= 0 pulls
  // rst_n low for edge rst_k and abandons the read.
  task automatic q_read(input logic [23:0] a, input int n_bytes, input int rst_k);
    int n;
    int idx;
    logic [7:0] b;
    logic [3:0] hi;
    n = 0;
    hi = 4'h0;
    rbuf.delete();
    q_cmd(8'hEB);
    q_addr(a, 6);
    for (int k = 8; k < 8 + int'(WaitCyc) + 2 * n_bytes; k++) begin
      cyc(1'b0, 1'b0, 4'h0);
      if (k == rst_k) begin
        rst_n   = 1'b0;
        m_qpi   = 1'b0;
        m_armed = 1'b0;
        m_last  = 8'h00;
        e_busy  = 1'b0;
        cyc(1'b0, 1'b0, 4'h0);
        rst_n  = 1'b1;
        e_busy = 1'b1;
        cyc(1'b0, 1'b0, 4'h0);
        end_window();
        return;
      end
      if (k >= 8 + int'(WaitCyc)) begin
        n     = k - 8 - int'(WaitCyc);
        idx   = (int'(a[AddrBits-1:0]) + n / 2) % Depth;
        b     = m_mem[idx];
        e_sio = (n % 2 == 0) ? b[7:4] : b[3:0];
      end
      @(posedge mem_clk);
      #2;
      if (k >= 8 + int'(WaitCyc)) begin
        if (n % 2 == 0) hi = mem_sio;
        else rbuf.push_back({hi, mem_sio});
      end
    end
    end_window();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no end of run, want finish within bound");
    $fatal(1);
  end

  logic [23:0] ra;
  int          rlen;

  initial begin
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 4'h0);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 4'h0);

    // SPI init: armed reset in SPI mode, then enter QPI.
    spi_cmd(8'h66);
    spi_cmd(8'h99);
    spi_cmd(8'h35);
    check("init qpi", 32'(qpi_mode), 32'h1);
    check("init last", 32'(last_cmd), 32'h35);
    // 99h without a preceding 66h must not reset.
    q_cmd(8'h99);
    end_window();
    check("lone 99h", 32'(qpi_mode), 32'h1);

    // Fill the whole RAM so every later read has a known model value.
    wbuf.delete();
    for (int i = 0; i < int'(Depth); i++) wbuf.push_back(8'($urandom));
    q_write(24'h000000, 2 * int'(Depth));

    // 16-bit word ABCDh lands as two bytes, MSB first.
    wbuf.delete();
    wbuf.push_back(8'hAB);
    wbuf.push_back(8'hCD);
    q_write(24'h000010, 4);
    q_read(24'h000010, 2, -1);
    check("word byte0", 32'(rbuf[0]), 32'hAB);
    check("word byte1", 32'(rbuf[1]), 32'hCD);

    // Burst across the top of the RAM wraps to 000.
    wbuf.delete();
    wbuf.push_back(8'h11);
    wbuf.push_back(8'h22);
    wbuf.push_back(8'h33);
    wbuf.push_back(8'h44);
    q_write(24'h0003FE, 8);
    q_read(24'h0003FE, 4, -1);
    check("wrap rd0", 32'(rbuf[0]), 32'h11);
    check("wrap rd3", 32'(rbuf[3]), 32'h44);
    q_read(24'h000000, 2, -1);
    check("wrap low0", 32'(rbuf[0]), 32'h33);
    check("wrap low1", 32'(rbuf[1]), 32'h44);

    // Write aborted after three address nibbles leaves data untouched.
    q_cmd(8'h38);
    q_addr(24'h000010, 3);
    end_window();
    q_read(24'h000010, 2, -1);
    check("abort byte0", 32'(rbuf[0]), 32'hAB);
    check("abort byte1", 32'(rbuf[1]), 32'hCD);

    // Half-written trailing byte is dropped.
    wbuf.delete();
    wbuf.push_back(8'h5A);
    wbuf.push_back(8'h77);
    q_write(24'h000020, 3);
    q_read(24'h000020, 2, -1);
    check("half byte0", 32'(rbuf[0]), 32'h5A);
    check("half byte1", 32'(rbuf[1]), 32'(m_mem[32'h21]));

    // Unsupported QPI command: error pulse, bus stays released.
    q_cmd(8'hA5);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'h0);
    end_window();
    check("bad cmd last", 32'(last_cmd), 32'hA5);
    q_read(24'h000010, 2, -1);
    check("after err", 32'(rbuf[0]), 32'hAB);

    // Randomized bursts, read back with a byte of margin on each side.
    for (int it = 0; it < 8; it++) begin
      ra   = 24'($urandom);
      rlen = int'($urandom_range(1, 8));
      wbuf.delete();
      for (int j = 0; j < rlen; j++) wbuf.push_back(8'($urandom));
      q_write(ra, 2 * rlen);
      q_read(ra - 24'd1, rlen + 2, -1);
      q_read(24'($urandom), int'($urandom_range(1, 4)), -1);
    end

    // QPI exit, re-entry, and armed soft reset from QPI mode.
    q_cmd(8'hF5);
    end_window();
    check("f5 exit", 32'(qpi_mode), 32'h0);
    spi_cmd(8'h35);
    q_cmd(8'h66);
    end_window();
    q_cmd(8'h99);
    end_window();
    check("qpi soft rst", 32'(qpi_mode), 32'h0);
    spi_cmd(8'h35);

    // Reset in the middle of read data; RAM must survive.
    q_read(24'h0003FE, 4, 8 + int'(WaitCyc) + 3);
    check("rst qpi", 32'(qpi_mode), 32'h0);
    spi_cmd(8'h35);
    q_read(24'h000010, 2, -1);
    check("post rst0", 32'(rbuf[0]), 32'hAB);
    check("post rst1", 32'(rbuf[1]), 32'hCD);
    q_read(24'h0003FE, 4, -1);

    cyc(1'b1, 1'b0, 4'h0);
    @(posedge mem_clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
